// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encoding and helpers
// for the round pipeline stages.
package aes_pkg;

    localparam int         AES_NR        = 10;
    localparam logic [7:0] AES_RCON_INIT = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SUB0,
        ST_SUB1,
        ST_SUB2,
        ST_SUB3,
        ST_UPD,
        ST_WRAP
    } ark_state_e;

    // GF(2^8) multiply by x, reducing with the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // RotWord({a,b,c,d}) = {b,c,d,a}
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Word i of a key; w0 is the most significant word
    function automatic logic [31:0] key_word(input logic [127:0] k,
                                             input logic [1:0]   i);
        logic [31:0] w;
        case (i)
            2'd0:    w = k[127:96];
            2'd1:    w = k[95:64];
            2'd2:    w = k[63:32];
            default: w = k[31:0];
        endcase
        return w;
    endfunction

    // Byte i of a word; byte 0 is the most significant byte
    function automatic logic [7:0] word_byte(input logic [31:0] w,
                                             input logic [1:0]  i);
        logic [7:0] b;
        case (i)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational.
// One instance per lookup port.
module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);

    localparam logic [2047:0] TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] base;

    // Entry 0 sits in the top byte of the table
    always_comb begin
        base = 11'd2047 - {a_i, 3'b000};
        y_o  = TAB[base -: 8];
    end

endmodule

// File: rtl/add_round_key_stage.sv
// AES-128 AddRoundKey stage with an iterative on-the-fly
// key schedule and a registered valid/ready output.
module add_round_key_stage
    import aes_pkg::*;
#(
    parameter int         NR        = AES_NR,
    parameter logic [7:0] RCON_INIT = AES_RCON_INIT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_load,
    input  logic [127:0] key_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic [3:0]   round_idx,
    output logic         last_round,
    output logic         key_valid
);

    ark_state_e   state_q, state_d;
    logic [127:0] key0_q, key0_d;
    logic [127:0] cur_key_q, cur_key_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   round_q, round_d;
    logic [31:0]  tmp_q, tmp_d;
    logic [127:0] dout_q, dout_d;
    logic         ovalid_q, ovalid_d;
    logic         kvalid_q, kvalid_d;

    logic         accept;
    logic         is_last;
    logic [1:0]   sub_idx;
    logic [7:0]   sbox_in;
    logic [7:0]   sbox_out;
    logic [31:0]  w0n, w1n, w2n, w3n;

    aes_sbox u_sbox (
        .a_i (sbox_in),
        .y_o (sbox_out)
    );

    // Handshake: a held result blocks intake unless it drains now
    always_comb begin
        is_last  = (round_q == 4'(NR));
        in_ready = (state_q == ST_WAIT) && !key_load
                   && (!ovalid_q || out_ready);
        accept   = in_valid && in_ready;
    end

    // Select the RotWord(w3) byte for the current SUB cycle
    always_comb begin
        sub_idx = 2'd0;
        case (state_q)
            ST_SUB1: sub_idx = 2'd1;
            ST_SUB2: sub_idx = 2'd2;
            ST_SUB3: sub_idx = 2'd3;
            default: sub_idx = 2'd0;
        endcase
        sbox_in = word_byte(rot_word(key_word(cur_key_q, 2'd3)), sub_idx);
    end

    // Next round key from the current key and the gathered S-box word
    always_comb begin
        w0n = key_word(cur_key_q, 2'd0) ^ tmp_q ^ {rcon_q, 24'h0};
        w1n = key_word(cur_key_q, 2'd1) ^ w0n;
        w2n = key_word(cur_key_q, 2'd2) ^ w1n;
        w3n = key_word(cur_key_q, 2'd3) ^ w2n;
    end

    // FSM next state, key schedule and output register updates
    always_comb begin
        state_d   = state_q;
        key0_d    = key0_q;
        cur_key_d = cur_key_q;
        rcon_d    = rcon_q;
        round_d   = round_q;
        tmp_d     = tmp_q;
        dout_d    = dout_q;
        ovalid_d  = ovalid_q;
        kvalid_d  = kvalid_q;

        if (out_ready) begin
            ovalid_d = 1'b0;
        end

        if (key_load) begin
            key0_d    = key_in;
            cur_key_d = key_in;
            round_d   = 4'd0;
            rcon_d    = RCON_INIT;
            ovalid_d  = 1'b0;
            kvalid_d  = 1'b1;
            state_d   = ST_WAIT;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_WAIT: begin
                    if (accept) begin
                        dout_d   = state_in ^ cur_key_q;
                        ovalid_d = 1'b1;
                        state_d  = is_last ? ST_WRAP : ST_SUB0;
                    end
                end
                ST_SUB0: begin
                    tmp_d[31:24] = sbox_out;
                    state_d      = ST_SUB1;
                end
                ST_SUB1: begin
                    tmp_d[23:16] = sbox_out;
                    state_d      = ST_SUB2;
                end
                ST_SUB2: begin
                    tmp_d[15:8] = sbox_out;
                    state_d     = ST_SUB3;
                end
                ST_SUB3: begin
                    tmp_d[7:0] = sbox_out;
                    state_d    = ST_UPD;
                end
                ST_UPD: begin
                    cur_key_d = {w0n, w1n, w2n, w3n};
                    round_d   = round_q + 4'd1;
                    rcon_d    = xtime(rcon_q);
                    state_d   = ST_WAIT;
                end
                ST_WRAP: begin
                    cur_key_d = key0_q;
                    round_d   = 4'd0;
                    rcon_d    = RCON_INIT;
                    state_d   = ST_WAIT;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            key0_q    <= '0;
            cur_key_q <= '0;
            rcon_q    <= RCON_INIT;
            round_q   <= '0;
            tmp_q     <= '0;
            dout_q    <= '0;
            ovalid_q  <= 1'b0;
            kvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            key0_q    <= key0_d;
            cur_key_q <= cur_key_d;
            rcon_q    <= rcon_d;
            round_q   <= round_d;
            tmp_q     <= tmp_d;
            dout_q    <= dout_d;
            ovalid_q  <= ovalid_d;
            kvalid_q  <= kvalid_d;
        end
    end

    assign state_out  = dout_q;
    assign out_valid  = ovalid_q;
    assign round_idx  = round_q;
    assign last_round = is_last;
    assign key_valid  = kvalid_q;

endmodule

// File: tb/tb_add_round_key_stage.sv
// Scoreboard bench for add_round_key_stage against
// published AES-128 round-key vectors.
module tb_add_round_key_stage;

    logic         clk;
    logic         rst;
    logic         key_load;
    logic [127:0] key_in;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic [3:0]   round_idx;
    logic         last_round;
    logic         key_valid;

    add_round_key_stage dut (
        .clk        (clk),
        .rst        (rst),
        .key_load   (key_load),
        .key_in     (key_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .state_in   (state_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .state_out  (state_out),
        .round_idx  (round_idx),
        .last_round (last_round),
        .key_valid  (key_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic [127:0] rk_a [0:10] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe,
        128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd,
        128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b,
        128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2,
        128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };

    logic [127:0] rk_b [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    int           n_cmp = 0;
    int           n_bad = 0;
    int           tb_round = 0;
    int           key_sel = 0;
    logic [127:0] exp_q [$];

    function automatic logic [127:0] rk(input int sel, input int r);
        return (sel == 0) ? rk_a[r] : rk_b[r];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_key_load(input logic [127:0] k, input int sel);
        @(negedge clk);
        key_load = 1'b1;
        key_in   = k;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        key_load = 1'b0;
        tb_round = 0;
        key_sel  = sel;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        key_load  = 1'b0;
        key_in    = '0;
        in_valid  = 1'b1;
        state_in  = 128'h1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (state_out !== '0)
            $display("FAIL rst_state_out: got %h want 0", state_out);
        if (state_out !== '0) n_bad++;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_valid_ready: got %b/%b want 0/0",
                     out_valid, in_ready);
        end
        n_cmp++;
        if (round_idx !== 4'd0 || last_round !== 1'b0 || key_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_round_key: got %0d/%b/%b want 0/0/0",
                     round_idx, last_round, key_valid);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL nokey_idle: in_ready=%b out_valid=%b want 0/0",
                         in_ready, out_valid);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_round_sweep();
        int           acc = 0;
        int           cyc = 0;
        logic [127:0] exp_v;
        do_key_load(KEY_A, 0);
        while ((acc < 13 || exp_q.size() != 0) && cyc < 400) begin
            @(negedge clk);
            in_valid  = (acc < 13);
            state_in  = '0;
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sweep_extra: state_out=%h want no output",
                             state_out);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (state_out !== exp_v) begin
                        n_bad++;
                        $display("FAIL sweep_out: got %h want %h",
                                 state_out, exp_v);
                    end
                end
            end
            if (in_valid && in_ready) begin
                n_cmp++;
                if (round_idx !== 4'(tb_round)) begin
                    n_bad++;
                    $display("FAIL sweep_round: got %0d want %0d",
                             round_idx, tb_round);
                end
                n_cmp++;
                if (last_round !== (tb_round == 10)) begin
                    n_bad++;
                    $display("FAIL sweep_last: got %b want %b",
                             last_round, (tb_round == 10));
                end
                exp_q.push_back(state_in ^ rk(key_sel, tb_round));
                tb_round = (tb_round == 10) ? 0 : tb_round + 1;
                acc++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (acc < 13 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL sweep_timeout: accepts=%0d want 13 pending=%0d",
                     acc, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int           acc = 0;
        int           cyc = 0;
        int           stall_left = 0;
        bit           stalled = 0;
        bit           prev_hold = 0;
        logic [127:0] prev_out = '0;
        logic [127:0] exp_v;
        logic [127:0] sin = rand128();
        while ((acc < 12 || exp_q.size() != 0) && cyc < 600) begin
            @(negedge clk);
            in_valid  = (acc < 12);
            state_in  = sin;
            out_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 1) == 1);
            #1;
            if (prev_hold) begin
                n_cmp++;
                if (out_valid !== 1'b1 || state_out !== prev_out) begin
                    n_bad++;
                    $display("FAIL bp_hold: got %b/%h want 1/%h",
                             out_valid, state_out, prev_out);
                end
            end
            if (out_valid && !out_ready) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL bp_in_ready: got %b want 0", in_ready);
                end
            end
            if (stall_left == 1) begin
                n_cmp++;
                if (round_idx !== 4'(tb_round)) begin
                    n_bad++;
                    $display("FAIL bp_round_frozen: got %0d want %0d",
                             round_idx, tb_round);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL bp_extra: state_out=%h want no output",
                             state_out);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (state_out !== exp_v) begin
                        n_bad++;
                        $display("FAIL bp_out: got %h want %h",
                                 state_out, exp_v);
                    end
                end
            end
            if (stall_left > 0) stall_left--;
            if (in_valid && in_ready) begin
                n_cmp++;
                if (round_idx !== 4'(tb_round)) begin
                    n_bad++;
                    $display("FAIL bp_round: got %0d want %0d",
                             round_idx, tb_round);
                end
                exp_q.push_back(sin ^ rk(key_sel, tb_round));
                tb_round = (tb_round == 10) ? 0 : tb_round + 1;
                sin = rand128();
                acc++;
                if (!stalled) begin
                    stalled    = 1;
                    stall_left = 20;
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_out  = state_out;
            cyc++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (acc < 12 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL bp_timeout: accepts=%0d want 12 pending=%0d",
                     acc, exp_q.size());
        end
    endtask

    task automatic test_key_reload();
        int           acc = 0;
        int           cyc = 0;
        bit           found = 0;
        logic [127:0] exp_v;
        do_key_load(KEY_A, 0);
        while (!found && cyc < 100) begin
            @(negedge clk);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            state_in  = rand128();
            #1;
            if (round_idx == 4'd4 && in_ready) found = 1;
            cyc++;
        end
        out_ready = 1'b0;
        #1;
        n_cmp++;
        if (!found || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reload_reach_r4: round=%0d in_ready=%b want 4/1",
                     round_idx, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        key_load = 1'b1;
        key_in   = KEY_B;
        in_valid = 1'b1;
        state_in = rand128();
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reload_pending: out_valid=%b in_ready=%b want 1/0",
                     out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        key_load = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || round_idx !== 4'd0 || key_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL reload_state: %b/%0d/%b want 0/0/1",
                     out_valid, round_idx, key_valid);
        end
        tb_round = 0;
        key_sel  = 1;
        exp_q.delete();
        cyc = 0;
        while ((acc < 11 || exp_q.size() != 0) && cyc < 400) begin
            @(negedge clk);
            in_valid  = (acc < 11);
            state_in  = '0;
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL reload_extra: state_out=%h want no output",
                             state_out);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (state_out !== exp_v) begin
                        n_bad++;
                        $display("FAIL reload_out: got %h want %h",
                                 state_out, exp_v);
                    end
                end
            end
            if (in_valid && in_ready) begin
                n_cmp++;
                if (round_idx !== 4'(tb_round)) begin
                    n_bad++;
                    $display("FAIL reload_round: got %0d want %0d",
                             round_idx, tb_round);
                end
                exp_q.push_back(state_in ^ rk(key_sel, tb_round));
                tb_round = (tb_round == 10) ? 0 : tb_round + 1;
                acc++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (acc < 11 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL reload_timeout: accepts=%0d want 11 pending=%0d",
                     acc, exp_q.size());
        end
    endtask

    task automatic test_rst_mid();
        logic [127:0] sin = rand128();
        do_key_load(KEY_A, 0);
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        state_in  = sin;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_accept: in_ready=%b want 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || state_out !== (sin ^ rk_a[0])) begin
            n_bad++;
            $display("FAIL rstmid_r0: got %b/%h want 1/%h",
                     out_valid, state_out, sin ^ rk_a[0]);
        end
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (state_out !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_out: got %h/%b/%b want 0/0/0",
                     state_out, out_valid, in_ready);
        end
        n_cmp++;
        if (round_idx !== 4'd0 || last_round !== 1'b0 || key_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_round: got %0d/%b/%b want 0/0/0",
                     round_idx, last_round, key_valid);
        end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL rstmid_ignore: in_ready=%b out_valid=%b want 0/0",
                         in_ready, out_valid);
            end
        end
        do_key_load(KEY_A, 0);
        @(negedge clk);
        in_valid = 1'b1;
        state_in = '0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || state_out !== rk_a[0]) begin
            n_bad++;
            $display("FAIL rstmid_recover: got %b/%h want 1/%h",
                     out_valid, state_out, rk_a[0]);
        end
    endtask

    initial begin
        test_reset();
        test_round_sweep();
        test_backpressure();
        test_key_reload();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
